// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit for the MEM stage.
// Turns one load/store into one or two aligned bus beats with byte enables,
// steers store bytes onto their lanes and sign/zero-extends load results.
// Accesses that straddle a bus word are split into two beats when
// ALLOW_MISALIGNED=1; otherwise any misaligned access is answered with
// misalign_o and never reaches the bus.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   op_valid_i        op present; held stable while stall_o=1
//   op_we_i           1=store, 0=load
//   op_size_i         0=byte 1=half 2=word 3=double (double only if XLEN=64)
//   op_unsigned_i     loads: 1=zero-extend, 0=sign-extend
//   op_addr_i         byte address
//   op_sdata_i        store data, right-justified
//   stall_o           pipeline stall request (combinational)
//   done_o            1-cycle completion pulse
//   ldata_o           extended load result, 0 when done_o=0
//   misalign_o        1-cycle pulse with done_o: illegal size/alignment
//   req_o, req_we_o   bus request / write
//   req_addr_o        bus-word-aligned address
//   req_be_o          byte enables
//   req_wdata_o       lane-steered store data
//   bus_done_i        beat completed this cycle
//   bus_rdata_i       read data, valid with bus_done_i
module mem_access_unit #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned ADDR_W           = 32,
    parameter int unsigned ALLOW_MISALIGNED = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid_i,
    input  logic                op_we_i,
    input  logic [1:0]          op_size_i,
    input  logic                op_unsigned_i,
    input  logic [ADDR_W-1:0]   op_addr_i,
    input  logic [XLEN-1:0]     op_sdata_i,
    output logic                stall_o,
    output logic                done_o,
    output logic [XLEN-1:0]     ldata_o,
    output logic                misalign_o,
    output logic                req_o,
    output logic                req_we_o,
    output logic [ADDR_W-1:0]   req_addr_o,
    output logic [XLEN/8-1:0]   req_be_o,
    output logic [XLEN-1:0]     req_wdata_o,
    input  logic                bus_done_i,
    input  logic [XLEN-1:0]     bus_rdata_i
);

    localparam int unsigned BUS_BYTES = XLEN / 8;
    localparam int unsigned OFF_W     = $clog2(BUS_BYTES);
    localparam int unsigned MASK_W    = 2 * BUS_BYTES;
    localparam bit          DOUBLE_OK = (XLEN == 64);
    localparam bit          SPLIT_OK  = (ALLOW_MISALIGNED != 0);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t               state;

    // Captured operation
    logic                 we_q;
    logic [1:0]           size_q;
    logic                 unsigned_q;
    logic [OFF_W-1:0]     off_q;
    logic                 cross_q;
    logic                 misal_q;
    logic [XLEN-1:0]      sdata_q;
    logic [MASK_W-1:0]    mask_q;
    logic [XLEN-1:0]      rdata0_q;
    logic [XLEN-1:0]      rdata1_q;

    // Decode of the incoming op
    logic [OFF_W-1:0]     in_off;
    logic [3:0]           in_nbytes;
    logic                 in_legal;
    logic                 in_misal;
    logic                 in_cross;
    logic [MASK_W-1:0]    in_mask;
    logic [ADDR_W-1:0]    in_base;
    logic [XLEN-1:0]      in_wdata0;

    // Second-beat store data and load assembly
    logic [XLEN-1:0]      wdata1;
    logic [2*XLEN-1:0]    raw_wide;
    int unsigned          ld_bits;
    int unsigned          ld_shamt;
    logic [XLEN-1:0]      ld_left;
    logic signed [XLEN-1:0] ld_sext;
    logic [XLEN-1:0]      ld_ext;

    // Byte-enable mask spanning two bus words: nbytes ones starting at off
    function automatic logic [MASK_W-1:0] mask_f(input logic [OFF_W-1:0] off,
                                                 input logic [3:0] nb);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(MASK_W); i++) begin
            if (i >= int'(off) && i < int'(off) + int'(nb)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign stall_o = op_valid_i & ~done_o;

    // Decode of the op presented at the ports
    always_comb begin
        in_off    = op_addr_i[OFF_W-1:0];
        in_nbytes = 4'd1 << op_size_i;
        in_legal  = (op_size_i != 2'd3) || DOUBLE_OK;
        in_misal  = (op_addr_i[2:0] & 3'(in_nbytes - 4'd1)) != 3'd0;
        in_cross  = (5'(in_off) + 5'(in_nbytes)) > 5'(BUS_BYTES);
        in_mask   = mask_f(in_off, in_nbytes);
        in_base   = op_addr_i & ~ADDR_W'(BUS_BYTES - 1);
        in_wdata0 = op_sdata_i << {in_off, 3'b000};
    end

    // Upper bytes of the store that spill into the next bus word
    always_comb begin
        wdata1 = sdata_q >> ((BUS_BYTES - 32'(off_q)) * 32'd8);
    end

    // Load assembly: align both beats down by the offset, then extend from nbytes
    always_comb begin
        raw_wide = {rdata1_q, rdata0_q} >> {off_q, 3'b000};
        ld_bits  = 32'd8 << size_q;
        ld_shamt = (ld_bits >= XLEN) ? 32'd0 : (XLEN - ld_bits);
        ld_left  = raw_wide[XLEN-1:0] << ld_shamt;
        ld_sext  = $signed(ld_left) >>> ld_shamt;
        ld_ext   = unsigned_q ? (ld_left >> ld_shamt) : ld_sext;
    end

    // Control FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done_o      <= 1'b0;
            misalign_o  <= 1'b0;
            ldata_o     <= '0;
            req_o       <= 1'b0;
            req_we_o    <= 1'b0;
            req_addr_o  <= '0;
            req_be_o    <= '0;
            req_wdata_o <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            off_q       <= '0;
            cross_q     <= 1'b0;
            misal_q     <= 1'b0;
            sdata_q     <= '0;
            mask_q      <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o     <= 1'b0;
                    misalign_o <= 1'b0;
                    ldata_o    <= '0;
                    // The done_o cycle is skipped so a still-held op is not re-issued
                    if (op_valid_i && !done_o) begin
                        we_q       <= op_we_i;
                        size_q     <= op_size_i;
                        unsigned_q <= op_unsigned_i;
                        off_q      <= in_off;
                        cross_q    <= in_cross;
                        sdata_q    <= op_sdata_i;
                        mask_q     <= in_mask;
                        rdata0_q   <= '0;
                        rdata1_q   <= '0;
                        if (!in_legal || (in_misal && !SPLIT_OK)) begin
                            misal_q <= 1'b1;
                            state   <= RESP;
                        end else begin
                            misal_q     <= 1'b0;
                            state       <= BEAT0;
                            req_o       <= 1'b1;
                            req_we_o    <= op_we_i;
                            req_addr_o  <= in_base;
                            req_be_o    <= in_mask[BUS_BYTES-1:0];
                            req_wdata_o <= in_wdata0;
                        end
                    end
                end
                BEAT0: begin
                    if (bus_done_i) begin
                        rdata0_q <= bus_rdata_i;
                        if (cross_q) begin
                            // req_o stays high; address and lanes move to the next word
                            state       <= BEAT1;
                            req_addr_o  <= req_addr_o + ADDR_W'(BUS_BYTES);
                            req_be_o    <= mask_q[MASK_W-1:BUS_BYTES];
                            req_wdata_o <= wdata1;
                        end else begin
                            state       <= RESP;
                            req_o       <= 1'b0;
                            req_we_o    <= 1'b0;
                            req_addr_o  <= '0;
                            req_be_o    <= '0;
                            req_wdata_o <= '0;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_done_i) begin
                        rdata1_q    <= bus_rdata_i;
                        state       <= RESP;
                        req_o       <= 1'b0;
                        req_we_o    <= 1'b0;
                        req_addr_o  <= '0;
                        req_be_o    <= '0;
                        req_wdata_o <= '0;
                    end
                end
                RESP: begin
                    done_o     <= 1'b1;
                    misalign_o <= misal_q;
                    ldata_o    <= (we_q || misal_q) ? '0 : ld_ext;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (XLEN=32). Two instances: one
// splitting misaligned accesses, one rejecting them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_valid_na = 1'b0;
    logic        op_we = 1'b0;
    logic [1:0]  op_size = 2'd0;
    logic        op_uns = 1'b0;
    logic [31:0] op_addr = 32'h0;
    logic [31:0] op_sdata = 32'h0;
    logic        bus_done = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    logic        stall, done, misalign, req, req_we;
    logic [31:0] ldata, req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        stall_na, done_na, misalign_na, req_na, req_we_na;
    logic [31:0] ldata_na, req_addr_na, req_wdata_na;
    logic [3:0]  req_be_na;

    int checks = 0;
    int failures = 0;

    // Results captured by do_op
    int          r_done;
    logic [31:0] r_ld;
    logic        r_mis;
    int          r_beats;
    logic        r_stall_ok;
    logic [31:0] r_a [2];
    logic [3:0]  r_be [2];
    logic [31:0] r_wd [2];
    logic        r_we [2];

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_we_i(op_we),
        .op_size_i(op_size), .op_unsigned_i(op_uns), .op_addr_i(op_addr),
        .op_sdata_i(op_sdata), .stall_o(stall), .done_o(done), .ldata_o(ldata),
        .misalign_o(misalign), .req_o(req), .req_we_o(req_we),
        .req_addr_o(req_addr), .req_be_o(req_be), .req_wdata_o(req_wdata),
        .bus_done_i(bus_done), .bus_rdata_i(bus_rdata)
    );

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_na (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_na), .op_we_i(op_we),
        .op_size_i(op_size), .op_unsigned_i(op_uns), .op_addr_i(op_addr),
        .op_sdata_i(op_sdata), .stall_o(stall_na), .done_o(done_na),
        .ldata_o(ldata_na), .misalign_o(misalign_na), .req_o(req_na),
        .req_we_o(req_we_na), .req_addr_o(req_addr_na), .req_be_o(req_be_na),
        .req_wdata_o(req_wdata_na), .bus_done_i(bus_done), .bus_rdata_i(bus_rdata)
    );

    // Drop op_valid for one cycle
    task automatic idle();
        op_valid = 1'b0;
        op_valid_na = 1'b0;
        bus_done = 1'b0;
        @(posedge clk); #1;
    endtask

    // Present an op on dut and act as a bus with `waits` wait cycles per beat
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int waits, input logic [31:0] rd0, input logic [31:0] rd1);
        int cyc;
        int wcnt;
        int beat;
        op_valid = 1'b1; op_we = we; op_size = sz; op_uns = uns;
        op_addr = addr; op_sdata = sd;
        cyc = 0; wcnt = 0; beat = 0;
        r_done = -1; r_ld = 32'h0; r_mis = 1'b0; r_beats = 0; r_stall_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_a[i] = 32'h0; r_be[i] = 4'h0; r_wd[i] = 32'h0; r_we[i] = 1'b0;
        end
        while (cyc < 40 && r_done < 0) begin
            @(posedge clk); #1;
            cyc++;
            bus_done = 1'b0;
            bus_rdata = 32'h0;
            if (done) begin
                r_done = cyc; r_ld = ldata; r_mis = misalign;
            end else begin
                if (!stall) r_stall_ok = 1'b0;
                if (req) begin
                    if (wcnt == 0 && beat < 2) begin
                        r_a[beat] = req_addr; r_be[beat] = req_be;
                        r_wd[beat] = req_wdata; r_we[beat] = req_we;
                    end
                    if (wcnt == waits) begin
                        bus_done = 1'b1;
                        bus_rdata = (beat == 0) ? rd0 : rd1;
                        wcnt = 0;
                        beat++;
                        r_beats = beat;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", req); end
        checks++; if (done !== 1'b0 || misalign !== 1'b0) begin failures++; $display("FAIL reset_done got %b%b want 00", done, misalign); end
        checks++; if (ldata !== 32'h0 || req_addr !== 32'h0) begin failures++; $display("FAIL reset_data got %h %h want 0 0", ldata, req_addr); end
        checks++; if (req_be !== 4'h0 || req_wdata !== 32'h0 || req_we !== 1'b0) begin failures++; $display("FAIL reset_bus got %h %h %b want 0 0 0", req_be, req_wdata, req_we); end
        checks++; if (stall !== 1'b0 || req_na !== 1'b0) begin failures++; $display("FAIL reset_stall got %b %b want 0 0", stall, req_na); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_aligned();
        do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h0);
        checks++; if (r_done !== 3) begin failures++; $display("FAIL lw_latency got %0d want 3", r_done); end
        checks++; if (r_ld !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got %h want deadbeef", r_ld); end
        checks++; if (r_beats !== 1 || r_a[0] !== 32'h100 || r_be[0] !== 4'hF) begin failures++; $display("FAIL lw_beat got %0d %h %h want 1 00000100 f", r_beats, r_a[0], r_be[0]); end
        checks++; if (r_mis !== 1'b0 || r_we[0] !== 1'b0) begin failures++; $display("FAIL lw_flags got %b %b want 0 0", r_mis, r_we[0]); end
        idle();
        checks++; if (done !== 1'b0 || ldata !== 32'h0) begin failures++; $display("FAIL lw_pulse got %b %h want 0 0", done, ldata); end
    endtask

    task automatic test_load_extend();
        do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80112233, 32'h0);
        checks++; if (r_be[0] !== 4'b1000) begin failures++; $display("FAIL lb_be got %b want 1000", r_be[0]); end
        checks++; if (r_ld !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got %h want ffffff80", r_ld); end
        idle();
        do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80112233, 32'h0);
        checks++; if (r_ld !== 32'h00000080) begin failures++; $display("FAIL lbu_data got %h want 00000080", r_ld); end
        idle();
        do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, 32'h80112233, 32'h0);
        checks++; if (r_ld !== 32'hFFFF8011 || r_be[0] !== 4'b1100) begin failures++; $display("FAIL lh_data got %h %b want ffff8011 1100", r_ld, r_be[0]); end
        idle();
        do_op(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 0, 32'h80112233, 32'h0);
        checks++; if (r_ld !== 32'h00002233) begin failures++; $display("FAIL lhu_data got %h want 00002233", r_ld); end
        idle();
        // Misaligned but inside one word: single beat
        do_op(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0, 32'h00ABCD00, 32'h0);
        checks++; if (r_done !== 3 || r_beats !== 1 || r_be[0] !== 4'b0110) begin failures++; $display("FAIL lh101 got %0d %0d %b want 3 1 0110", r_done, r_beats, r_be[0]); end
        checks++; if (r_ld !== 32'hFFFFABCD || r_mis !== 1'b0) begin failures++; $display("FAIL lh101_data got %h %b want ffffabcd 0", r_ld, r_mis); end
        idle();
    endtask

    task automatic test_store_split();
        do_op(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000ABCD, 0, 32'h0, 32'h0);
        checks++; if (r_done !== 4 || r_beats !== 2) begin failures++; $display("FAIL sh_latency got %0d %0d want 4 2", r_done, r_beats); end
        checks++; if (r_a[0] !== 32'h100 || r_be[0] !== 4'b1000 || r_wd[0][31:24] !== 8'hCD) begin failures++; $display("FAIL sh_beat0 got %h %b %h want 00000100 1000 cd", r_a[0], r_be[0], r_wd[0][31:24]); end
        checks++; if (r_a[1] !== 32'h104 || r_be[1] !== 4'b0001 || r_wd[1][7:0] !== 8'hAB) begin failures++; $display("FAIL sh_beat1 got %h %b %h want 00000104 0001 ab", r_a[1], r_be[1], r_wd[1][7:0]); end
        checks++; if (r_we[0] !== 1'b1 || r_we[1] !== 1'b1 || r_ld !== 32'h0) begin failures++; $display("FAIL sh_we got %b%b %h want 11 0", r_we[0], r_we[1], r_ld); end
        idle();
        // Aligned word store: no steering
        do_op(1'b1, 2'd2, 1'b0, 32'h208, 32'h11223344, 0, 32'h0, 32'h0);
        checks++; if (r_done !== 3 || r_wd[0] !== 32'h11223344 || r_be[0] !== 4'hF) begin failures++; $display("FAIL sw got %0d %h %h want 3 11223344 f", r_done, r_wd[0], r_be[0]); end
        idle();
    endtask

    task automatic test_wait_split();
        do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 3, 32'h44331111, 32'h77776655);
        checks++; if (r_ld !== 32'h66554433) begin failures++; $display("FAIL lw_wait_data got %h want 66554433", r_ld); end
        checks++; if (r_done !== 10) begin failures++; $display("FAIL lw_wait_latency got %0d want 10", r_done); end
        checks++; if (r_stall_ok !== 1'b1) begin failures++; $display("FAIL lw_wait_stall got %b want 1", r_stall_ok); end
        checks++; if (r_be[0] !== 4'b1100 || r_be[1] !== 4'b0011 || r_a[1] !== 32'h104) begin failures++; $display("FAIL lw_wait_be got %b %b %h want 1100 0011 00000104", r_be[0], r_be[1], r_a[1]); end
        idle();
    endtask

    task automatic test_misalign();
        int  dcyc;
        logic saw_req;
        for (int t = 0; t < 2; t++) begin
            op_valid_na = 1'b1; op_we = 1'b0; op_uns = 1'b0; op_sdata = 32'h0;
            op_size = (t == 0) ? 2'd1 : 2'd3;
            op_addr = (t == 0) ? 32'h101 : 32'h100;
            dcyc = -1; saw_req = 1'b0;
            for (int c = 1; c <= 10 && dcyc < 0; c++) begin
                @(posedge clk); #1;
                if (req_na) saw_req = 1'b1;
                if (done_na) begin
                    dcyc = c;
                    checks++; if (misalign_na !== 1'b1 || ldata_na !== 32'h0) begin failures++; $display("FAIL na_flag%0d got %b %h want 1 0", t, misalign_na, ldata_na); end
                end
            end
            checks++; if (dcyc !== 2) begin failures++; $display("FAIL na_latency%0d got %0d want 2", t, dcyc); end
            checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL na_noreq%0d got %b want 0", t, saw_req); end
            idle();
        end
        // Double on a 32-bit unit is illegal even when splitting is allowed
        do_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h0, 32'h0);
        checks++; if (r_done !== 2 || r_mis !== 1'b1 || r_beats !== 0) begin failures++; $display("FAIL size3 got %0d %b %0d want 2 1 0", r_done, r_mis, r_beats); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, 32'hCAFEF00D, 32'h0);
        checks++; if (r_done !== 3 || r_ld !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_first got %0d %h want 3 cafef00d", r_done, r_ld); end
        // New op presented during the done cycle is only taken a cycle later
        do_op(1'b0, 2'd0, 1'b1, 32'h401, 32'h0, 0, 32'h0000A500, 32'h0);
        checks++; if (r_done !== 4 || r_ld !== 32'h000000A5) begin failures++; $display("FAIL b2b_second got %0d %h want 4 000000a5", r_done, r_ld); end
        checks++; if (r_a[0] !== 32'h400 || r_be[0] !== 4'b0010) begin failures++; $display("FAIL b2b_beat got %h %b want 00000400 0010", r_a[0], r_be[0]); end
        idle();
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op_we = 1'b0; op_size = 2'd2; op_uns = 1'b0;
        op_addr = 32'h200; op_sdata = 32'h0; bus_done = 1'b0;
        @(posedge clk); #1;
        checks++; if (req !== 1'b1) begin failures++; $display("FAIL rmid_req got %b want 1", req); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (req !== 1'b0 || req_be !== 4'h0 || done !== 1'b0) begin failures++; $display("FAIL rmid_abort got %b %h %b want 0 0 0", req, req_be, done); end
        rst = 1'b0;
        idle();
        do_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, 32'h12345678, 32'h0);
        checks++; if (r_done !== 3 || r_ld !== 32'h12345678 || r_a[0] !== 32'h300) begin failures++; $display("FAIL rmid_next got %0d %h %h want 3 12345678 00000300", r_done, r_ld, r_a[0]); end
        idle();
    endtask

    initial begin
        test_reset();
        test_lw_aligned();
        test_load_extend();
        test_store_split();
        test_wait_split();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
